imem_program_encoder: RTL
=========================

Name: imem_program_encoder

Overview:
- Sequential producer for the op field the single-cycle CPU's control decoder consumes.
- Accepts symbolic instruction requests over a valid/ready handshake and encodes each into a 32-bit MIPS word for one of four classes: R-type, lw, sw, j.
- Writes the encoded words to consecutive instruction-memory addresses.
- Holds the CPU out of run until loading completes, so it is the boot-time loader sitting in front of the instruction memory.

Parameters:
- ADDR_W, 6, word-address width of the instruction-memory write port.
- DEPTH, 64, maximum words loadable; must satisfy DEPTH <= 2^ADDR_W.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a load session.
- finish  input  1  one-cycle pulse; ends the session.
- in_valid  input  1  instruction request valid.
- in_ready  output  1  request accepted when in_valid && in_ready.
- kind  input  2  00 R-type, 01 lw, 10 sw, 11 j.
- rs  input  5  source register.
- rt  input  5  second source or target register.
- rd  input  5  destination register (R-type only).
- funct  input  6  function field (R-type only).
- imm  input  16  offset (lw/sw).
- target  input  26  jump target (j).
- imem_we  output  1  instruction-memory write strobe.
- imem_addr  output  ADDR_W  write word address.
- imem_wdata  output  32  encoded instruction.
- word_count  output  ADDR_W+1  words written this session.
- cpu_run  output  1  CPU may execute; 0 holds it in reset.
- overflow  output  1  sticky; in_valid seen while full.

Behaviour:
- Reset (async, immediate): state IDLE. in_ready, imem_we, cpu_run, overflow = 0. imem_addr, imem_wdata, word_count = 0.
- States:
  - IDLE: in_ready=0; start -> LOAD.
  - LOAD: in_ready = (word_count < DEPTH).
  - DONE: cpu_run=1, in_ready=0.
- Entering LOAD from IDLE or DONE: clear word_count and overflow, drop cpu_run the same edge.
- Encoding, by kind:
  - 00: {6'b000000, rs, rt, rd, 5'b00000, funct}.
  - 01: {6'b100011, rs, rt, imm}.
  - 10: {6'b101011, rs, rt, imm}.
  - 11: {6'b000010, target}.
  - Unused fields are ignored.
- Latency: an accept at edge N drives imem_we=1 during cycle N+1, with imem_addr = word_count before the increment (truncated to ADDR_W) and imem_wdata = the encoded word.
- word_count increments at the accepting edge. imem_we is a single-cycle pulse per accept.
- Back-to-back accepts are allowed every cycle, giving one write per cycle.
- Full: when word_count == DEPTH, in_ready=0. in_valid=1 while full sets overflow (sticky until next start or reset); nothing is written.
- finish in LOAD -> DONE at the next edge. cpu_run rises once the last pending imem_we has completed: if an accept coincides with finish, that word is written first and cpu_run rises the cycle after.
- finish outside LOAD is ignored. start while in LOAD is ignored.
- start and finish in the same cycle in IDLE or DONE: start wins.
- No address wrap: imem_addr never exceeds DEPTH-1.
- Reset mid-session discards the in-flight word; imem_we is forced to 0 immediately.

Test Plan:
- Reset, start, accept kind=00 rs=1 rt=2 rd=3 funct=0x20 -> one cycle later imem_we=1, addr=0, wdata=0x00221820; word_count=1.
- Back-to-back accepts: lw rs=1 rt=2 imm=4, then sw rs=0 rt=5 imm=8, then j target=0x10 -> writes 0x8C220004@0, 0xAC050008@1, 0x08000010@2 on consecutive cycles.
- finish coincident with the third accept -> third word written, then cpu_run=1 one cycle later; word_count=3; in_ready=0.
- DEPTH=4: after 4 accepts, in_ready=0; further in_valid -> overflow=1, no imem_we; a new start clears overflow and word_count and drops cpu_run.
- Assert reset mid-LOAD with a write pending -> imem_we, cpu_run, in_ready drop immediately; all outputs return to reset values.
- finish while in IDLE, and start while in LOAD -> no state change.

Source files
------------

// File: rtl/imem_program_encoder.sv
// imem_program_encoder
//   Boot-time loader that sits in front of the single-cycle CPU's instruction
//   memory. Symbolic instruction requests (R-type, lw, sw, j) arrive over a
//   valid/ready handshake. Each one is encoded into a 32-bit MIPS word and
//   written to consecutive instruction-memory addresses. The CPU is held out
//   of run until the session is finished.
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   start, finish         one-cycle pulses opening / closing a load session
//   in_valid, in_ready    request handshake (accept = in_valid && in_ready)
//   kind                  00 R-type, 01 lw, 10 sw, 11 j
//   rs, rt, rd, funct,
//   imm, target           instruction fields (unused fields ignored per kind)
//   imem_we, imem_addr,
//   imem_wdata            instruction-memory write port, one cycle after accept
//   word_count            words written in the current session
//   cpu_run               1 lets the CPU execute, 0 holds it in reset
//   overflow              sticky: a request was offered while the memory was full
module imem_program_encoder #(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        kind,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [5:0]        funct,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic              cpu_run,
  output logic              overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } loaderStateT;

  localparam logic [ADDR_W:0] DepthCount = (ADDR_W+1)'(DEPTH);

  loaderStateT       state;
  logic              accept;
  logic [ADDR_W:0]   countAfter;
  logic [31:0]       encWord;

  // Encode one symbolic request into its 32-bit MIPS instruction word.
  function automatic logic [31:0] encodeInstr(
    input logic [1:0]  k,
    input logic [4:0]  fRs,
    input logic [4:0]  fRt,
    input logic [4:0]  fRd,
    input logic [5:0]  fFunct,
    input logic [15:0] fImm,
    input logic [25:0] fTarget
  );
    logic [31:0] word;
    case (k)
      2'b00:   word = {6'b000000, fRs, fRt, fRd, 5'b00000, fFunct};
      2'b01:   word = {6'b100011, fRs, fRt, fImm};
      2'b10:   word = {6'b101011, fRs, fRt, fImm};
      2'b11:   word = {6'b000010, fTarget};
      default: word = 32'h0000_0000;
    endcase
    return word;
  endfunction

  // Handshake decode, post-accept count and the encoded word for this cycle.
  always_comb begin
    accept     = in_valid && in_ready;
    countAfter = word_count + {{ADDR_W{1'b0}}, accept};
    encWord    = encodeInstr(kind, rs, rt, rd, funct, imm, target);
  end

  // Loader FSM with all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= {ADDR_W{1'b0}};
      imem_wdata <= 32'h0000_0000;
      word_count <= {(ADDR_W+1){1'b0}};
      cpu_run    <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      // Write port: exactly one strobe per accept, address is the pre-increment
      // count. Since accepts only happen while count < DEPTH the address never
      // exceeds DEPTH-1.
      imem_we <= accept;
      if (accept) begin
        imem_addr  <= word_count[ADDR_W-1:0];
        imem_wdata <= encWord;
      end
      word_count <= countAfter;

      case (state)
        IDLE: begin
          if (start) begin
            state      <= LOAD;
            word_count <= {(ADDR_W+1){1'b0}};
            overflow   <= 1'b0;
            cpu_run    <= 1'b0;
            in_ready   <= ({(ADDR_W+1){1'b0}} < DepthCount);
          end else begin
            in_ready   <= 1'b0;
          end
        end
        LOAD: begin
          // in_ready is low exactly when full, so any offer now is dropped.
          if (in_valid && (word_count == DepthCount)) begin
            overflow <= 1'b1;
          end
          if (finish) begin
            state    <= DONE;
            in_ready <= 1'b0;
          end else begin
            in_ready <= (countAfter < DepthCount);
          end
        end
        DONE: begin
          // cpu_run rises one edge after entering DONE, which is after the
          // write for an accept that coincided with finish has completed.
          if (start) begin
            state      <= LOAD;
            word_count <= {(ADDR_W+1){1'b0}};
            overflow   <= 1'b0;
            cpu_run    <= 1'b0;
            in_ready   <= ({(ADDR_W+1){1'b0}} < DepthCount);
          end else begin
            cpu_run    <= 1'b1;
            in_ready   <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          cpu_run  <= 1'b0;
        end
      endcase
    end
  end

endmodule
